aes_ctr_seq: RTL and testbench

AES_CTR_SEQ -- requirements
Module: aes_ctr_seq

---
 rtl/aes_ctr_seq.sv | 197 +++++++++++++++++++
 tb/tb_aes_ctr_seq.sv | 567 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_seq.sv
// -----------------------------------------------------------------------------
// aes_ctr_seq
//
// Sequences AES-CTR encryption of a buffer of 128-bit blocks. For every block
// it presents the current counter block to an external AES core, reads the
// plaintext from a source buffer, XORs it with the returned keystream and
// writes the result to a destination buffer. The low CTR_W counter bits are
// incremented once per block. A run aborts if those bits would wrap while
// blocks remain.
//
// Parameters
//   DEPTH_W : log2 of buffer depth in 128-bit blocks
//   CTR_W   : number of low counter-block bits incremented per block (1..32)
//
// Ports
//   sys_clk, sys_rst        : clock, synchronous active-high reset
//   start, nblk             : one-cycle run request, number of blocks
//   nonce, iv, ctr_init     : counter block bits [127:96], [95:32], [31:0]
//   irq_clr                 : clears done_irq and wrap_err
//   aes_start, aes_in       : request and counter block to the AES core
//   aes_done, aes_out       : keystream-valid pulse and keystream block
//   src_addr, src_data      : plaintext read port (1-cycle read latency)
//   dst_addr, dst_data,
//   dst_we                  : ciphertext write port
//   busy                    : high whenever a run is in progress
//   done_irq, wrap_err      : sticky status flags
// -----------------------------------------------------------------------------
module aes_ctr_seq #(
  parameter int DEPTH_W = 4,
  parameter int CTR_W   = 32
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               start,
  input  logic [DEPTH_W:0]   nblk,
  input  logic [31:0]        nonce,
  input  logic [63:0]        iv,
  input  logic [31:0]        ctr_init,
  input  logic               irq_clr,
  output logic               aes_start,
  output logic [127:0]       aes_in,
  input  logic               aes_done,
  input  logic [127:0]       aes_out,
  output logic [DEPTH_W-1:0] src_addr,
  input  logic [127:0]       src_data,
  output logic [DEPTH_W-1:0] dst_addr,
  output logic [127:0]       dst_data,
  output logic               dst_we,
  output logic               busy,
  output logic               done_irq,
  output logic               wrap_err
);

  localparam int IW = DEPTH_W + 1;
  localparam logic [IW-1:0] MAX_BLK = {1'b1, {DEPTH_W{1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, WAIT, WRITE, NEXT} state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [IW-1:0]      nblk_q, nblk_d;
  logic [127:0]       ctr_q, ctr_d;
  logic [127:0]       pt_q, pt_d;
  logic [127:0]       dst_data_q, dst_data_d;
  logic               first_q, first_d;
  logic [DEPTH_W-1:0] src_addr_q, src_addr_d;
  logic [DEPTH_W-1:0] dst_addr_q, dst_addr_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic               done_set, wrap_set;

  logic [CTR_W-1:0]   ctr_lo;
  logic [IW-1:0]      idx_inc;

  assign ctr_lo  = ctr_q[CTR_W-1:0];
  assign idx_inc = idx_q + IW'(1);

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    nblk_d     = nblk_q;
    ctr_d      = ctr_q;
    pt_d       = pt_q;
    first_d    = 1'b0;
    src_addr_d = src_addr_q;
    dst_addr_d = dst_addr_q;
    dst_data_d = dst_data_q;
    done_set   = 1'b0;
    wrap_set   = 1'b0;
    aes_start  = 1'b0;
    dst_we     = 1'b0;
    busy       = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (nblk == '0) begin
            done_set = 1'b1;
          end else begin
            state_d    = LOAD;
            idx_d      = '0;
            nblk_d     = (nblk > MAX_BLK) ? MAX_BLK : nblk;
            ctr_d      = {nonce, iv, ctr_init};
            src_addr_d = '0;
          end
        end
      end

      LOAD: begin
        aes_start = 1'b1;
        first_d   = 1'b1;
        state_d   = WAIT;
      end

      WAIT: begin
        // The source read issued in LOAD returns during the first WAIT cycle.
        if (first_q) begin
          pt_d = src_data;
        end
        // With L=1 the keystream arrives in that same first cycle, so the
        // plaintext is taken straight from the read port instead of pt_q.
        if (aes_done) begin
          dst_data_d = aes_out ^ (first_q ? src_data : pt_q);
          dst_addr_d = idx_q[DEPTH_W-1:0];
          state_d    = WRITE;
        end
      end

      WRITE: begin
        dst_we  = 1'b1;
        state_d = NEXT;
      end

      NEXT: begin
        idx_d                = idx_inc;
        src_addr_d           = idx_inc[DEPTH_W-1:0];
        ctr_d[CTR_W-1:0]     = ctr_lo + CTR_W'(1);
        if (idx_inc == nblk_q) begin
          state_d  = IDLE;
          done_set = 1'b1;
        end else if (&ctr_lo) begin
          // Counter would repeat a keystream block: abort the run.
          state_d  = IDLE;
          done_set = 1'b1;
          wrap_set = 1'b1;
        end else begin
          state_d = LOAD;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A set in the same cycle as a clear takes precedence.
    done_d = done_set | (done_q & ~irq_clr);
    wrap_d = wrap_set | (wrap_q & ~irq_clr);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      nblk_q     <= '0;
      ctr_q      <= '0;
      pt_q       <= '0;
      first_q    <= 1'b0;
      src_addr_q <= '0;
      dst_addr_q <= '0;
      dst_data_q <= '0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      nblk_q     <= nblk_d;
      ctr_q      <= ctr_d;
      pt_q       <= pt_d;
      first_q    <= first_d;
      src_addr_q <= src_addr_d;
      dst_addr_q <= dst_addr_d;
      dst_data_q <= dst_data_d;
      done_q     <= done_d;
      wrap_q     <= wrap_d;
    end
  end

  assign aes_in   = ctr_q;
  assign src_addr = src_addr_q;
  assign dst_addr = dst_addr_q;
  assign dst_data = dst_data_q;
  assign done_irq = done_q;
  assign wrap_err = wrap_q;

endmodule

// File: tb/tb_aes_ctr_seq.sv
// -----------------------------------------------------------------------------
// tb_aes_ctr_seq
//
// Bench for aes_ctr_seq. Two instances are built: one with the default 32-bit
// counter and one with an 8-bit counter (for wrap scenarios); 'sel' chooses
// which one receives start and which one the memory/AES models talk to.
// The AES core is modelled as a fixed-latency keyed permutation and the source
// buffer as a registered-read array. Expected results come from a block-level
// reference model.
// -----------------------------------------------------------------------------
module tb_aes_ctr_seq;

  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic         sys_clk = 1'b0;
  logic         sys_rst, start, irq_clr, sel;
  logic [DW:0]  nblk;
  logic [31:0]  nonce, ctr_init;
  logic [63:0]  iv;
  logic         aes_done = 1'b0;
  logic [127:0] aes_out  = '0;
  logic [127:0] src_data = '0;

  logic          start_g     [2];
  logic          o_aes_start [2];
  logic [127:0]  o_aes_in    [2];
  logic [DW-1:0] o_src_addr  [2];
  logic [DW-1:0] o_dst_addr  [2];
  logic [127:0]  o_dst_data  [2];
  logic          o_dst_we    [2];
  logic          o_busy      [2];
  logic          o_done_irq  [2];
  logic          o_wrap_err  [2];

  logic          m_aes_start, m_dst_we, m_busy, m_done_irq, m_wrap_err;
  logic [127:0]  m_aes_in, m_dst_data;
  logic [DW-1:0] m_src_addr, m_dst_addr;

  assign start_g[0] = start & ~sel;
  assign start_g[1] = start & sel;

  assign m_aes_start = sel ? o_aes_start[1] : o_aes_start[0];
  assign m_aes_in    = sel ? o_aes_in[1]    : o_aes_in[0];
  assign m_src_addr  = sel ? o_src_addr[1]  : o_src_addr[0];
  assign m_dst_addr  = sel ? o_dst_addr[1]  : o_dst_addr[0];
  assign m_dst_data  = sel ? o_dst_data[1]  : o_dst_data[0];
  assign m_dst_we    = sel ? o_dst_we[1]    : o_dst_we[0];
  assign m_busy      = sel ? o_busy[1]      : o_busy[0];
  assign m_done_irq  = sel ? o_done_irq[1]  : o_done_irq[0];
  assign m_wrap_err  = sel ? o_wrap_err[1]  : o_wrap_err[0];

  aes_ctr_seq #(.DEPTH_W(DW), .CTR_W(32)) dut32 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_g[0]), .nblk(nblk),
    .nonce(nonce), .iv(iv), .ctr_init(ctr_init), .irq_clr(irq_clr),
    .aes_start(o_aes_start[0]), .aes_in(o_aes_in[0]), .aes_done(aes_done),
    .aes_out(aes_out), .src_addr(o_src_addr[0]), .src_data(src_data),
    .dst_addr(o_dst_addr[0]), .dst_data(o_dst_data[0]), .dst_we(o_dst_we[0]),
    .busy(o_busy[0]), .done_irq(o_done_irq[0]), .wrap_err(o_wrap_err[0])
  );

  aes_ctr_seq #(.DEPTH_W(DW), .CTR_W(8)) dut8 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start_g[1]), .nblk(nblk),
    .nonce(nonce), .iv(iv), .ctr_init(ctr_init), .irq_clr(irq_clr),
    .aes_start(o_aes_start[1]), .aes_in(o_aes_in[1]), .aes_done(aes_done),
    .aes_out(aes_out), .src_addr(o_src_addr[1]), .src_data(src_data),
    .dst_addr(o_dst_addr[1]), .dst_data(o_dst_data[1]), .dst_we(o_dst_we[1]),
    .busy(o_busy[1]), .done_irq(o_done_irq[1]), .wrap_err(o_wrap_err[1])
  );

  always #5 sys_clk = ~sys_clk;

  logic [127:0] src_mem [DEPTH];
  logic [127:0] key;
  int           tests_run    = 0;
  int           tests_failed = 0;
  int           lat_cur      = 1;
  int           aes_cnt      = 0;
  logic [127:0] aes_blk      = '0;

  // Observations
  logic [127:0] obs_ain[$];
  logic [127:0] obs_data[$];
  int           obs_addr[$];
  int           obs_cycles;
  logic         obs_done, obs_wrap, obs_busy_start, obs_busy_after;

  // Expectations
  logic [127:0] exp_ain[$];
  logic [127:0] exp_data[$];
  logic         exp_wrap;
  int           exp_cycles;

  function automatic logic [127:0] ks(input logic [127:0] x);
    return {x[94:0], x[127:95]} ^ key;
  endfunction

  // Source buffer: one-cycle registered read.
  always @(posedge sys_clk) src_data <= src_mem[m_src_addr];

  // AES core: keystream appears L cycles after the request cycle.
  always @(negedge sys_clk) begin
    aes_done = 1'b0;
    if (aes_cnt > 0) begin
      aes_cnt--;
      if (aes_cnt == 0) begin
        aes_done = 1'b1;
        aes_out  = ks(aes_blk);
      end
    end
    if (m_aes_start) begin
      aes_cnt = lat_cur;
      aes_blk = m_aes_in;
    end
  end

  always @(negedge sys_clk) begin
    if (m_aes_start) obs_ain.push_back(m_aes_in);
    if (m_dst_we) begin
      obs_addr.push_back(int'(m_dst_addr));
      obs_data.push_back(m_dst_data);
    end
  end

  task automatic step();
    @(negedge sys_clk);
    #1;
  endtask

  // Reference: block i uses counter low bits (ctr_init + i) mod 2^w; the run
  // stops after a block whose low bits are all ones if blocks remain.
  task automatic model_run(input int n_req, input logic [31:0] nn, input logic [63:0] ivv,
                           input logic [31:0] ci, input int w, input int lat);
    int n;
    longint unsigned modv, mask, low, base;
    logic [127:0] blk;
    exp_ain.delete();
    exp_data.delete();
    exp_wrap = 1'b0;
    n    = (n_req > DEPTH) ? DEPTH : n_req;
    modv = 64'd1 << w;
    mask = modv - 64'd1;
    base = {32'd0, ci};
    for (int i = 0; i < n; i++) begin
      low = ((base & mask) + 64'(i)) % modv;
      blk = {nn, ivv, 32'((base & ~mask) | low)};
      exp_ain.push_back(blk);
      exp_data.push_back(ks(blk) ^ src_mem[i]);
      if (i < n - 1 && low == mask) begin
        exp_wrap = 1'b1;
        break;
      end
    end
    exp_cycles = exp_ain.size() * (3 + lat);
  endtask

  // Launch one run and record what the DUT does. With 'disturb', a second
  // start plus new parameter values are driven while the run is in flight.
  task automatic run_collect(input int n_req, input logic [31:0] nn, input logic [63:0] ivv,
                             input logic [31:0] ci, input int lat, input bit disturb);
    int cyc;
    int limit;
    lat_cur = lat;
    limit   = DEPTH * (3 + lat) + 20;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    obs_ain.delete();
    obs_addr.delete();
    obs_data.delete();
    nblk     = (DW+1)'(n_req);
    nonce    = nn;
    iv       = ivv;
    ctr_init = ci;
    start    = 1'b1;
    step();
    start = 1'b0;
    obs_busy_start = m_busy;
    cyc = 0;
    while (!m_done_irq && cyc < limit) begin
      step();
      cyc++;
      if (disturb && cyc == 3) begin
        start    = 1'b1;
        nblk     = (DW+1)'($urandom_range(0, 31));
        nonce    = $urandom;
        iv       = {$urandom, $urandom};
        ctr_init = $urandom;
      end
      if (disturb && cyc == 4) start = 1'b0;
    end
    start      = 1'b0;
    obs_cycles = cyc;
    obs_done   = m_done_irq;
    obs_wrap   = m_wrap_err;
    repeat ((3 + lat) * 2 + 4) step();
    obs_busy_after = m_busy;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      tests_run++;
      if ({m_aes_start, m_dst_we, m_busy, m_done_irq, m_wrap_err} !== 5'b0) begin
        tests_failed++;
        $display("FAIL reset_ctrl[%0d]: got %b, expected 00000", s,
                 {m_aes_start, m_dst_we, m_busy, m_done_irq, m_wrap_err});
      end
      tests_run++;
      if (m_aes_in !== '0 || m_dst_data !== '0 || m_src_addr !== '0 || m_dst_addr !== '0) begin
        tests_failed++;
        $display("FAIL reset_data[%0d]: got aes_in=%h dst_data=%h src=%h dst=%h, expected all 0",
                 s, m_aes_in, m_dst_data, m_src_addr, m_dst_addr);
      end
    end
    sel     = 1'b0;
    sys_rst = 1'b0;
    step();
  endtask

  task automatic test_single_block();
    logic [127:0] blk;
    blk = 128'h60000000C97256DBB2F0A87A00000001;
    sel = 1'b0;
    run_collect(1, 32'h60000000, 64'hC97256DBB2F0A87A, 32'h1, 14, 1'b0);
    tests_run++;
    if (obs_ain.size() != 1) begin
      tests_failed++;
      $display("FAIL single_nstart: got %0d, expected 1", obs_ain.size());
    end else begin
      tests_run++;
      if (obs_ain[0] !== blk) begin
        tests_failed++;
        $display("FAIL single_aes_in: got %h, expected %h", obs_ain[0], blk);
      end
    end
    tests_run++;
    if (obs_addr.size() != 1) begin
      tests_failed++;
      $display("FAIL single_nwrite: got %0d, expected 1", obs_addr.size());
    end else begin
      tests_run++;
      if (obs_addr[0] != 0 || obs_data[0] !== (ks(blk) ^ src_mem[0])) begin
        tests_failed++;
        $display("FAIL single_write: got addr=%0d data=%h, expected addr=0 data=%h",
                 obs_addr[0], obs_data[0], ks(blk) ^ src_mem[0]);
      end
    end
    tests_run++;
    if (obs_cycles != 17 || obs_done !== 1'b1 || obs_wrap !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_done: got cycles=%0d done=%b wrap=%b, expected 17 1 0",
               obs_cycles, obs_done, obs_wrap);
    end
  endtask

  task automatic test_full_buffer();
    logic [31:0] nn;
    logic [63:0] ivv;
    nn  = $urandom;
    ivv = {$urandom, $urandom};
    sel = 1'b0;
    run_collect(16, nn, ivv, 32'h0, 1, 1'b0);
    model_run(16, nn, ivv, 32'h0, 32, 1);
    tests_run++;
    if (obs_addr.size() != 16 || obs_ain.size() != 16) begin
      tests_failed++;
      $display("FAIL full_count: got writes=%0d starts=%0d, expected 16 16",
               obs_addr.size(), obs_ain.size());
    end
    for (int i = 0; i < obs_addr.size() && i < 16; i++) begin
      tests_run++;
      if (obs_addr[i] != i || obs_data[i] !== exp_data[i]) begin
        tests_failed++;
        $display("FAIL full_write[%0d]: got addr=%0d data=%h, expected addr=%0d data=%h",
                 i, obs_addr[i], obs_data[i], i, exp_data[i]);
      end
    end
    for (int i = 0; i < obs_ain.size() && i < 16; i++) begin
      tests_run++;
      if (obs_ain[i][31:0] !== 32'(i)) begin
        tests_failed++;
        $display("FAIL full_ctr[%0d]: got %h, expected %h", i, obs_ain[i][31:0], 32'(i));
      end
    end
    tests_run++;
    if (obs_cycles != 64 || obs_busy_start !== 1'b1 || obs_busy_after !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_timing: got cycles=%0d busy_run=%b busy_after=%b, expected 64 1 0",
               obs_cycles, obs_busy_start, obs_busy_after);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] nn;
    logic [63:0] ivv;
    int lat;
    nn  = $urandom;
    ivv = {$urandom, $urandom};
    lat = $urandom_range(1, 4);
    sel = 1'b1;
    run_collect(4, nn, ivv, 32'h000000FE, lat, 1'b0);
    model_run(4, nn, ivv, 32'h000000FE, 8, lat);
    tests_run++;
    if (obs_ain.size() != 2 || obs_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL wrap_count: got starts=%0d writes=%0d, expected 2 2",
               obs_ain.size(), obs_addr.size());
    end else begin
      tests_run++;
      if (obs_ain[0][31:0] !== 32'h000000FE || obs_ain[1][31:0] !== 32'h000000FF) begin
        tests_failed++;
        $display("FAIL wrap_ctr: got %h %h, expected 000000fe 000000ff",
                 obs_ain[0][31:0], obs_ain[1][31:0]);
      end
      tests_run++;
      if (obs_data[0] !== exp_data[0] || obs_data[1] !== exp_data[1] || obs_addr[1] != 1) begin
        tests_failed++;
        $display("FAIL wrap_data: got %h %h, expected %h %h",
                 obs_data[0], obs_data[1], exp_data[0], exp_data[1]);
      end
    end
    tests_run++;
    if (obs_wrap !== 1'b1 || obs_done !== 1'b1 || obs_cycles != 2 * (3 + lat)) begin
      tests_failed++;
      $display("FAIL wrap_flags: got wrap=%b done=%b cycles=%0d, expected 1 1 %0d",
               obs_wrap, obs_done, obs_cycles, 2 * (3 + lat));
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    tests_run++;
    if ({m_done_irq, m_wrap_err} !== 2'b00) begin
      tests_failed++;
      $display("FAIL wrap_irq_clr: got %b, expected 00", {m_done_irq, m_wrap_err});
    end
    // Counter reaching all ones on the final block is not a wrap.
    run_collect(2, nn, ivv, 32'h123456FE, lat, 1'b0);
    tests_run++;
    if (obs_wrap !== 1'b0 || obs_done !== 1'b1 || obs_addr.size() != 2) begin
      tests_failed++;
      $display("FAIL wrap_final8: got wrap=%b done=%b writes=%0d, expected 0 1 2",
               obs_wrap, obs_done, obs_addr.size());
    end else begin
      tests_run++;
      if (obs_ain[1][31:0] !== 32'h123456FF) begin
        tests_failed++;
        $display("FAIL wrap_upper: got %h, expected 123456ff", obs_ain[1][31:0]);
      end
    end
    sel = 1'b0;
    run_collect(1, nn, ivv, 32'hFFFFFFFF, lat, 1'b0);
    tests_run++;
    if (obs_wrap !== 1'b0 || obs_done !== 1'b1 || obs_addr.size() != 1) begin
      tests_failed++;
      $display("FAIL wrap_final32: got wrap=%b done=%b writes=%0d, expected 0 1 1",
               obs_wrap, obs_done, obs_addr.size());
    end
  endtask

  task automatic test_edge_cases();
    sel     = 1'b0;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    obs_ain.delete();
    nblk  = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    tests_run++;
    if (m_done_irq !== 1'b1 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_blk: got done=%b busy=%b, expected 1 0", m_done_irq, m_busy);
    end
    repeat (8) step();
    tests_run++;
    if (obs_ain.size() != 0) begin
      tests_failed++;
      $display("FAIL zero_blk_start: got %0d aes_start, expected 0", obs_ain.size());
    end
    run_collect(31, 32'hA5A5A5A5, 64'h0123456789ABCDEF, 32'h10, 1, 1'b0);
    tests_run++;
    if (obs_addr.size() != 16 || obs_cycles != 64) begin
      tests_failed++;
      $display("FAIL clamp: got writes=%0d cycles=%0d, expected 16 64",
               obs_addr.size(), obs_cycles);
    end
    run_collect(3, 32'h11112222, 64'h3333444455556666, 32'h7, 2, 1'b1);
    model_run(3, 32'h11112222, 64'h3333444455556666, 32'h7, 32, 2);
    tests_run++;
    if (obs_addr.size() != 3 || obs_ain.size() != 3 || obs_cycles != 15) begin
      tests_failed++;
      $display("FAIL start_busy: got writes=%0d starts=%0d cycles=%0d, expected 3 3 15",
               obs_addr.size(), obs_ain.size(), obs_cycles);
    end else begin
      tests_run++;
      if (obs_ain[2] !== exp_ain[2] || obs_data[2] !== exp_data[2]) begin
        tests_failed++;
        $display("FAIL start_busy_data: got %h/%h, expected %h/%h",
                 obs_ain[2], obs_data[2], exp_ain[2], exp_data[2]);
      end
    end
  endtask

  task automatic test_irq_coincident();
    sel     = 1'b0;
    lat_cur = 1;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    nblk    = 5'd1;
    start   = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    tests_run++;
    if (m_done_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_set_wins: got done=%b, expected 1", m_done_irq);
    end
    step();
    tests_run++;
    if (m_done_irq !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_hold: got done=%b, expected 1", m_done_irq);
    end
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    tests_run++;
    if (m_done_irq !== 1'b0) begin
      tests_failed++;
      $display("FAIL irq_clear: got done=%b, expected 0", m_done_irq);
    end
  endtask

  task automatic test_reset_midrun();
    int cyc;
    sel     = 1'b0;
    lat_cur = 5;
    irq_clr = 1'b1;
    step();
    irq_clr = 1'b0;
    obs_ain.delete();
    obs_addr.delete();
    obs_data.delete();
    nblk  = 5'd4;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 0;
    while (obs_ain.size() < 2 && cyc < 100) begin
      step();
      cyc++;
    end
    tests_run++;
    if (obs_ain.size() < 2 || obs_addr.size() != 1) begin
      tests_failed++;
      $display("FAIL rst_mid_setup: got starts=%0d writes=%0d, expected 2 1",
               obs_ain.size(), obs_addr.size());
    end
    step();
    sys_rst = 1'b1;
    step();
    tests_run++;
    if ({m_aes_start, m_dst_we, m_busy, m_done_irq, m_wrap_err} !== 5'b0 ||
        m_aes_in !== '0 || m_dst_data !== '0 || m_src_addr !== '0 || m_dst_addr !== '0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: got ctrl=%b aes_in=%h dst_data=%h, expected all 0",
               {m_aes_start, m_dst_we, m_busy, m_done_irq, m_wrap_err}, m_aes_in, m_dst_data);
    end
    sys_rst = 1'b0;
    obs_ain.delete();
    obs_addr.delete();
    obs_data.delete();
    repeat (20) step();
    tests_run++;
    if (obs_ain.size() != 0 || obs_addr.size() != 0 || m_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_after: got starts=%0d writes=%0d busy=%b, expected 0 0 0",
               obs_ain.size(), obs_addr.size(), m_busy);
    end
  endtask

  task automatic test_random();
    int n, lat, w, r;
    logic [31:0] nn, ci;
    logic [63:0] ivv;
    for (int it = 0; it < 12; it++) begin
      sel = 1'($urandom_range(0, 1));
      w   = sel ? 8 : 32;
      n   = $urandom_range(1, 20);
      lat = $urandom_range(1, 6);
      nn  = $urandom;
      ivv = {$urandom, $urandom};
      ci  = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        r = $urandom_range(0, 3);
        if (w == 8) ci[7:0] = 8'hFF - 8'(r);
        else        ci      = 32'hFFFFFFFF - 32'(r);
      end
      run_collect(n, nn, ivv, ci, lat, 1'($urandom_range(0, 1)));
      model_run(n, nn, ivv, ci, w, lat);
      tests_run++;
      if (obs_ain.size() != exp_ain.size() || obs_addr.size() != exp_ain.size()) begin
        tests_failed++;
        $display("FAIL rand%0d_count: got starts=%0d writes=%0d, expected %0d",
                 it, obs_ain.size(), obs_addr.size(), exp_ain.size());
      end
      for (int i = 0; i < obs_addr.size() && i < exp_ain.size() && i < obs_ain.size(); i++) begin
        tests_run++;
        if (obs_ain[i] !== exp_ain[i] || obs_addr[i] != i || obs_data[i] !== exp_data[i]) begin
          tests_failed++;
          $display("FAIL rand%0d_blk%0d: got ain=%h addr=%0d data=%h, expected ain=%h addr=%0d data=%h",
                   it, i, obs_ain[i], obs_addr[i], obs_data[i], exp_ain[i], i, exp_data[i]);
        end
      end
      tests_run++;
      if (obs_wrap !== exp_wrap || obs_done !== 1'b1 || obs_cycles != exp_cycles ||
          obs_busy_after !== 1'b0) begin
        tests_failed++;
        $display("FAIL rand%0d_status: got wrap=%b done=%b cycles=%0d busy=%b, expected %b 1 %0d 0",
                 it, obs_wrap, obs_done, obs_cycles, obs_busy_after, exp_wrap, exp_cycles);
      end
    end
  endtask

  initial begin
    sys_rst  = 1'b1;
    start    = 1'b0;
    irq_clr  = 1'b0;
    sel      = 1'b0;
    nblk     = '0;
    nonce    = '0;
    iv       = '0;
    ctr_init = '0;
    key      = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < DEPTH; i++) src_mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_single_block();
    test_full_buffer();
    test_wrap();
    test_edge_cases();
    test_irq_coincident();
    test_reset_midrun();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
